fmeasure_sequencer: RTL and testbench
=====================================

// Module: fmeasure_sequencer
//
// PURPOSE
//   Sequences the frequency-measurement unit. Issues start pulses in one-shot
//   or continuous mode and waits for each measurement to finish. Captures the
//   measured count pair into an output register and delivers it to a consumer
//   over a valid/ready handshake. Enforces a hold-off gap between measurements
//   and a busy-timeout watchdog.
//   Sits between the measurement unit and the display/host-interface logic.
//
// PARAMETERS
//   HOLDOFF    default 16         idle cycles between result accept and next start (0 allowed)
//   TIMEOUT    default 100000000  max cycles meas_busy may stay high before fault
//   ARM_LIMIT  default 4          max cycles from start pulse to meas_busy rising
//
// PORTS
//   clk        in   1   system clock; all logic on posedge
//   rst_n      in   1   asynchronous active-low reset
//   enable     in   1   continuous mode: keep launching while high
//   single     in   1   one-cycle pulse: request one measurement
//   clear      in   1   one-cycle pulse: clear fault, return to IDLE
//   meas_start out  1   start pulse to measurement unit
//   meas_busy  in   1   measurement unit busy
//   meas_ca    in   32  count A from unit; valid when meas_busy low
//   meas_cb    in   32  count B from unit; valid when meas_busy low
//   res_valid  out  1   result available
//   res_ready  in   1   consumer accepts result
//   res_ca     out  32  captured count A
//   res_cb     out  32  captured count B
//   seq_busy   out  1   high in any state other than IDLE and FAULT
//   fault      out  1   sticky watchdog fault (ARM or RUN timeout)
//   meas_cnt   out  16  completed measurements; wraps 0xFFFF->0
//
// BEHAVIOUR
//   - Reset values: all outputs 0; state IDLE; all counters 0.
//   - States and transitions:
//       IDLE: (single | enable) -> START. single wins if both are high;
//             both paths are identical.
//       START: meas_start=1 for exactly this one cycle -> ARM.
//       ARM: meas_busy=1 -> RUN; ARM_LIMIT cycles without busy -> FAULT.
//       RUN: meas_busy=0 sampled -> capture meas_ca/cb into res_ca/cb,
//            meas_cnt+1, -> DELIVER; TIMEOUT cycles in RUN -> FAULT.
//       DELIVER: res_valid=1; handshake when res_valid & res_ready ->
//            HOLDOFF (or IDLE if HOLDOFF==0).
//       HOLDOFF: count HOLDOFF cycles -> IDLE.
//       FAULT: fault=1; res_valid=0; clear -> IDLE (fault drops next cycle).
//   - meas_start is registered. Launch latency: IDLE request sampled at edge N
//     -> meas_start high in cycle N+1.
//   - res_valid is registered and high from the cycle after capture until
//     accepted.
//   - res_ca/res_cb are stable while res_valid is high. They hold their value
//     after acceptance and change only at the next capture.
//   - Backpressure: no new start is issued while a result is unaccepted. No
//     result is ever dropped or overwritten.
//   - single pulses arriving outside IDLE are ignored (not queued).
//   - If enable drops mid-measurement, the current measurement completes and is
//     delivered; no further launch.
//   - clear outside FAULT has no effect.
//   - fault stays set until clear, even if meas_busy later falls.
//   - Watchdog counters restart on every entry to ARM/RUN. TIMEOUT counts
//     cycles spent in RUN only.
//   - meas_cnt increments only on successful capture, never on fault.
//   - Async reset mid-operation: immediate return to IDLE, all outputs 0.
//     The measurement unit must be reset by the same rst_n.
//
// TESTING
//   1. Reset, then single pulse; unit busy 10 cycles, ca=1000, cb=250
//      -> one meas_start pulse; res_valid with res_ca=1000, res_cb=250;
//      meas_cnt=1.
//   2. enable=1, res_ready=1, HOLDOFF=16
//      -> consecutive meas_start pulses spaced by (busy duration + 16 + fixed
//      overhead) cycles, checked exactly; meas_cnt increments each time.
//   3. enable=1, res_ready=0 for 200 cycles
//      -> exactly one capture, res_valid held, res_ca/cb stable,
//      no second meas_start until ready.
//   4. Unit never raises busy -> fault=1 after ARM_LIMIT=4 cycles; clear pulse
//      -> fault=0, IDLE; meas_cnt unchanged.
//   5. TIMEOUT=50, busy stuck high -> fault at cycle 50 of RUN; single ignored
//      while in FAULT.
//   6. rst_n low during RUN -> all outputs 0 asynchronously. meas_cnt wraps
//      after 65536 captures (reduced-run check with forced counter).

Source files
------------

// File: rtl/fmeasure_sequencer.sv
// fmeasure_sequencer
//   Sequences a frequency-measurement unit. It launches measurements with a
//   one-cycle start pulse, either once (single) or repeatedly (enable). It then
//   waits for the unit to finish, captures the count pair and hands it to a
//   consumer over a valid/ready handshake. An enforced hold-off gap separates
//   measurements. Watchdogs cover a unit that never goes busy (ARM) and a unit
//   that stays busy too long (RUN). Either watchdog sets a sticky fault.
//
// Ports
//   clk, rst_n         clock (posedge) and asynchronous active-low reset
//   enable             continuous mode: keep launching while high
//   single             one-cycle request for a single measurement
//   clear              one-cycle pulse: leave FAULT, return to IDLE
//   meas_start         registered start pulse to the measurement unit
//   meas_busy          measurement unit busy
//   meas_ca, meas_cb   count pair from the unit, valid while meas_busy is low
//   res_valid          captured result available
//   res_ready          consumer accepts the result
//   res_ca, res_cb     captured count pair (held until the next capture)
//   seq_busy           high in every state except IDLE and FAULT
//   fault              sticky watchdog fault
//   meas_cnt           completed measurements, wraps at 16 bits
module fmeasure_sequencer #(
  parameter int HOLDOFF   = 16,
  parameter int TIMEOUT   = 100000000,
  parameter int ARM_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        single,
  input  logic        clear,
  output logic        meas_start,
  input  logic        meas_busy,
  input  logic [31:0] meas_ca,
  input  logic [31:0] meas_cb,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_ca,
  output logic [31:0] res_cb,
  output logic        seq_busy,
  output logic        fault,
  output logic [15:0] meas_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ARM, S_RUN, S_DELIVER, S_HOLD, S_FAULT
  } state_t;

  // Terminal values of the shared wait counter. The counter starts at 0 on
  // entry to a state. It therefore reaches LIMIT-1 on the last allowed cycle.
  localparam logic [31:0] ARM_LAST  = 32'(ARM_LIMIT - 1);
  localparam logic [31:0] RUN_LAST  = 32'(TIMEOUT - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF - 1);

  state_t      state;
  logic [31:0] wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      meas_start <= 1'b0;
      res_valid  <= 1'b0;
      res_ca     <= '0;
      res_cb     <= '0;
      seq_busy   <= 1'b0;
      fault      <= 1'b0;
      meas_cnt   <= '0;
    end else begin
      meas_start <= 1'b0;
      case (state)
        S_IDLE: begin
          // single and enable launch in exactly the same way.
          if (single || enable) begin
            state      <= S_START;
            meas_start <= 1'b1;
            seq_busy   <= 1'b1;
          end
        end

        S_START: begin
          state <= S_ARM;
          wcnt  <= '0;
        end

        S_ARM: begin
          if (meas_busy) begin
            state <= S_RUN;
            wcnt  <= '0;
          end else if (wcnt == ARM_LAST) begin
            state    <= S_FAULT;
            fault    <= 1'b1;
            seq_busy <= 1'b0;
          end else begin
            wcnt <= wcnt + 32'd1;
          end
        end

        S_RUN: begin
          if (!meas_busy) begin
            res_ca    <= meas_ca;
            res_cb    <= meas_cb;
            meas_cnt  <= meas_cnt + 16'd1;
            res_valid <= 1'b1;
            state     <= S_DELIVER;
          end else if (wcnt == RUN_LAST) begin
            state    <= S_FAULT;
            fault    <= 1'b1;
            seq_busy <= 1'b0;
          end else begin
            wcnt <= wcnt + 32'd1;
          end
        end

        S_DELIVER: begin
          // Nothing is launched until the consumer has taken the result.
          if (res_ready) begin
            res_valid <= 1'b0;
            wcnt      <= '0;
            if (HOLDOFF == 0) begin
              state    <= S_IDLE;
              seq_busy <= 1'b0;
            end else begin
              state <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (wcnt == HOLD_LAST) begin
            state    <= S_IDLE;
            seq_busy <= 1'b0;
          end else begin
            wcnt <= wcnt + 32'd1;
          end
        end

        S_FAULT: begin
          if (clear) begin
            state <= S_IDLE;
            fault <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          res_valid <= 1'b0;
          seq_busy  <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmeasure_sequencer.sv
`timescale 1ns/1ps
module tb_fmeasure_sequencer;

  localparam int HOLDOFF   = 16;
  localparam int TIMEOUT   = 50;
  localparam int ARM_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, single, clear;
  logic        meas_start, meas_busy;
  logic [31:0] meas_ca, meas_cb;
  logic        res_valid, res_ready;
  logic [31:0] res_ca, res_cb;
  logic        seq_busy, fault;
  logic [15:0] meas_cnt;

  always #5 clk = ~clk;

  fmeasure_sequencer #(
    .HOLDOFF   (HOLDOFF),
    .TIMEOUT   (TIMEOUT),
    .ARM_LIMIT (ARM_LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .single     (single),
    .clear      (clear),
    .meas_start (meas_start),
    .meas_busy  (meas_busy),
    .meas_ca    (meas_ca),
    .meas_cb    (meas_cb),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_ca     (res_ca),
    .res_cb     (res_cb),
    .seq_busy   (seq_busy),
    .fault      (fault),
    .meas_cnt   (meas_cnt)
  );

  typedef struct {
    logic [31:0] ca;
    logic [31:0] cb;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          starts[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cycle    = 0;
  int          model_mode = 0;   // 0 normal, 1 never busy, 2 stuck busy
  int          busy_len   = 10;
  logic [31:0] next_ca = 32'd1000;
  logic [31:0] next_cb = 32'd250;
  logic [15:0] exp_cnt = 16'd0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Measurement unit model: busy is raised in the start cycle and is held for
  // busy_len cycles. Then the count pair is presented and the expected result
  // is pushed to the scoreboard.
  initial begin
    meas_busy = 1'b0;
    meas_ca   = '0;
    meas_cb   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && meas_start) begin
        if (model_mode == 0) begin
          meas_busy = 1'b1;
          repeat (busy_len) @(negedge clk);
          meas_ca   = next_ca;
          meas_cb   = next_cb;
          meas_busy = 1'b0;
          exp_cnt   = exp_cnt + 16'd1;
          sb_q.push_back('{ca: next_ca, cb: next_cb, cnt: exp_cnt});
          next_ca   = next_ca + 32'd7;
          next_cb   = next_cb + 32'd3;
        end else if (model_mode == 2) begin
          meas_busy = 1'b1;
        end
      end
    end
  end

  // Start pulse logger (cycle stamps).
  initial forever begin
    @(negedge clk);
    if (rst_n && meas_start) starts.push_back(cycle);
  end

  // Scoreboard: compare on every accepted result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_res_ca", res_ca, e.ca);
          check_eq("sb_res_cb", res_cb, e.cb);
          check_eq("sb_meas_cnt", meas_cnt, e.cnt);
        end
      end
    end
  end

  task automatic drive_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_single();
    drive_tick(); single = 1'b1;
    drive_tick(); single = 1'b0;
  endtask

  task automatic pulse_clear();
    drive_tick(); clear = 1'b1;
    drive_tick(); clear = 1'b0;
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int k = 0;
    while (starts.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (starts.size() < n) check_eq(tag, 64'(starts.size()), 64'(n));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((seq_busy || res_valid) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (seq_busy || res_valid) check_eq(tag, {62'd0, seq_busy, res_valid}, 64'd0);
  endtask

  task automatic wait_cycle(input int c);
    while (cycle < c) @(negedge clk);
  endtask

  initial begin
    int t0;
    int k;
    rst_n = 1'b0; enable = 1'b0; single = 1'b0; clear = 1'b0; res_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    check_eq("rst_meas_start", meas_start, 1'b0);
    check_eq("rst_res_valid", res_valid, 1'b0);
    check_eq("rst_seq_busy", seq_busy, 1'b0);
    check_eq("rst_fault", fault, 1'b0);
    check_eq("rst_meas_cnt", meas_cnt, 16'd0);
    check_eq("rst_res_ca", res_ca, 32'd0);
    drive_tick(); rst_n = 1'b1;

    // 1: single measurement, busy 10 cycles, ca=1000 cb=250
    starts.delete();
    busy_len = 10;
    pulse_single();
    wait_starts("t1_start_timeout", 1, 20);
    k = 0;
    while (!res_valid && k < 50) begin @(negedge clk); k++; end
    check_eq("t1_res_valid", res_valid, 1'b1);
    check_eq("t1_res_ca", res_ca, 32'd1000);
    check_eq("t1_res_cb", res_cb, 32'd250);
    check_eq("t1_meas_cnt", meas_cnt, 16'd1);
    drive_tick(); res_ready = 1'b1;
    wait_idle("t1_idle_timeout", 60);
    check_eq("t1_start_count", 64'(starts.size()), 64'd1);

    // 2: continuous mode. The start-to-start gap is START(1) + ARM(1) +
    // RUN(busy_len-1) + DELIVER(1) + HOLDOFF + IDLE(1).
    busy_len = 7;
    starts.delete();
    drive_tick(); enable = 1'b1;
    wait_starts("t2_start_timeout", 4, 400);
    drive_tick(); enable = 1'b0;
    for (int i = 1; i < 4 && i < starts.size(); i++)
      check_eq("t2_start_gap", 64'(starts[i] - starts[i-1]), 64'(1 + 1 + (busy_len - 1) + 1 + HOLDOFF + 1));
    wait_idle("t2_idle_timeout", 100);
    check_eq("t2_meas_cnt", meas_cnt, 16'd5);
    check_eq("t2_sb_empty", 64'(sb_q.size()), 64'd0);

    // 3: backpressure. res_ready is held low for 200 cycles.
    busy_len = 12;
    res_ready = 1'b0;
    starts.delete();
    enable = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("t3_start_count", 64'(starts.size()), 64'd1);
    check_eq("t3_res_valid_held", res_valid, 1'b1);
    check_eq("t3_sb_pending", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      check_eq("t3_res_ca_stable", res_ca, sb_q[0].ca);
      check_eq("t3_res_cb_stable", res_cb, sb_q[0].cb);
    end
    drive_tick(); res_ready = 1'b1; enable = 1'b0;
    wait_idle("t3_idle_timeout", 60);
    check_eq("t3_no_relaunch", 64'(starts.size()), 64'd1);
    check_eq("t3_meas_cnt", meas_cnt, 16'd6);

    // 4: unit never raises busy, so the ARM watchdog fires.
    model_mode = 1;
    starts.delete();
    pulse_single();
    wait_starts("t4_start_timeout", 1, 20);
    t0 = (starts.size() > 0) ? starts[0] : cycle;
    wait_cycle(t0 + ARM_LIMIT);
    check_eq("t4_fault_early", fault, 1'b0);
    check_eq("t4_busy_in_arm", seq_busy, 1'b1);
    wait_cycle(t0 + ARM_LIMIT + 1);
    check_eq("t4_fault_set", fault, 1'b1);
    check_eq("t4_busy_in_fault", seq_busy, 1'b0);
    pulse_clear();
    check_eq("t4_fault_cleared", fault, 1'b0);
    check_eq("t4_meas_cnt_kept", meas_cnt, 16'd6);

    // 5: busy stuck high, so the RUN timeout fires; single is ignored in FAULT.
    model_mode = 2;
    starts.delete();
    pulse_single();
    wait_starts("t5_start_timeout", 1, 20);
    t0 = (starts.size() > 0) ? starts[0] : cycle;
    wait_cycle(t0 + 1 + TIMEOUT);
    check_eq("t5_fault_early", fault, 1'b0);
    wait_cycle(t0 + 2 + TIMEOUT);
    check_eq("t5_fault_set", fault, 1'b1);
    pulse_single();
    repeat (5) @(negedge clk);
    check_eq("t5_single_ignored", 64'(starts.size()), 64'd1);
    meas_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t5_fault_sticky", fault, 1'b1);
    check_eq("t5_meas_cnt_kept", meas_cnt, 16'd6);
    pulse_clear();
    check_eq("t5_fault_cleared", fault, 1'b0);

    // 6: asynchronous reset in RUN
    starts.delete();
    pulse_single();
    wait_starts("t6_start_timeout", 1, 20);
    t0 = (starts.size() > 0) ? starts[0] : cycle;
    wait_cycle(t0 + 5);
    check_eq("t6_busy_before_rst", seq_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_seq_busy", seq_busy, 1'b0);
    check_eq("t6_res_valid", res_valid, 1'b0);
    check_eq("t6_fault", fault, 1'b0);
    check_eq("t6_meas_start", meas_start, 1'b0);
    check_eq("t6_meas_cnt", meas_cnt, 16'd0);
    check_eq("t6_res_ca", res_ca, 32'd0);
    check_eq("t6_res_cb", res_cb, 32'd0);
    meas_busy  = 1'b0;
    model_mode = 0;
    exp_cnt    = 16'd0;
    repeat (3) drive_tick();
    rst_n = 1'b1;

    // meas_cnt wrap: preload 0xFFFF, then one capture must report 0.
    drive_tick();
    force dut.meas_cnt = 16'hFFFF;
    drive_tick();
    release dut.meas_cnt;
    check_eq("wrap_preload", meas_cnt, 16'hFFFF);
    exp_cnt  = 16'hFFFF;
    busy_len = 3;
    starts.delete();
    pulse_single();
    wait_starts("wrap_start_timeout", 1, 20);
    wait_idle("wrap_idle_timeout", 60);
    check_eq("wrap_meas_cnt", meas_cnt, 16'd0);
    check_eq("wrap_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
